// File: rtl/axi_stream_rr_arbiter.sv
// N:1 valid/ready arbiter with payload mux for one AXI channel.
// Supports round-robin or fixed priority. The grant is held while the
// granted beat is stalled, and optionally until a beat with last=1.
module axi_stream_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int PRIO_MODE    = 0,
    parameter int LOCK_ON_LAST = 0,
    parameter int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              in_valid_i,
    output logic [NUM_REQ-1:0]              in_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data_i,
    input  logic [NUM_REQ-1:0]              in_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic                            out_last_o,
    output logic [IDX_W-1:0]                out_sel_o
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W:0]     scan_idx;
    logic               sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic               hs, done;

    // Choose the requester presented downstream this cycle.
    always_comb begin
        scan_idx = '0;
        sel      = (PRIO_MODE == 1) ? '0 : rr_ptr_q;
        if (state_q == LOCKED) begin
            sel = lock_idx_q;
        end else begin
            // Walk the scan order backwards so the earliest valid match wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (PRIO_MODE == 1) begin
                    scan_idx = (IDX_W+1)'(k);
                end else begin
                    scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                    if (scan_idx >= (IDX_W+1)'(NUM_REQ))
                        scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
                end
                if (in_valid_i[scan_idx[IDX_W-1:0]])
                    sel = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign sel_valid = in_valid_i[sel];
    assign sel_last  = in_last_i[sel];
    assign sel_data  = in_data_i[sel*DATA_WIDTH +: DATA_WIDTH];

    assign hs   = sel_valid & out_ready_i;
    assign done = (LOCK_ON_LAST == 1) ? (hs & sel_last) : hs;

    // Outputs are held at zero while reset is asserted.
    assign out_valid_o = ~rst_i & sel_valid;
    assign out_last_o  = ~rst_i & sel_last;
    assign out_data_o  = rst_i ? '0 : sel_data;
    assign out_sel_o   = rst_i ? '0 : sel;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign in_ready_o[i] = ~rst_i & out_ready_i & (sel == IDX_W'(i));
    end

    // Lock/unlock decisions and round-robin pointer advance.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            UNLOCKED: begin
                if (sel_valid && !done) begin
                    state_d    = LOCKED;
                    lock_idx_d = sel;
                end
            end
            LOCKED: begin
                if (done) state_d = UNLOCKED;
            end
            default: state_d = UNLOCKED;
        endcase
        if (done)
            rr_ptr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= UNLOCKED;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A locked requester must keep valid high until its transfer completes.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == LOCKED)
            assert (in_valid_i[lock_idx_q]);
    end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Bench for axi_stream_rr_arbiter: three instances (round-robin, round-robin
// with burst lock, fixed priority), directed scenarios plus random traffic
// checked against a grant-ownership model.
module tb_axi_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0]    in_v[3], in_l[3], in_r[3];
    logic [N*DW-1:0] in_d[3];
    logic            o_rdy[3], o_v[3], o_l[3];
    logic [DW-1:0]   o_d[3];
    logic [IW-1:0]   o_s[3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_stream_rr_arbiter #(
            .NUM_REQ(N), .DATA_WIDTH(DW),
            .PRIO_MODE((g == 2) ? 1 : 0),
            .LOCK_ON_LAST((g == 1) ? 1 : 0)
        ) u_dut (
            .clk_i(clk), .rst_i(rst),
            .in_valid_i(in_v[g]), .in_ready_o(in_r[g]),
            .in_data_i(in_d[g]), .in_last_i(in_l[g]),
            .out_valid_o(o_v[g]), .out_ready_i(o_rdy[g]),
            .out_data_o(o_d[g]), .out_last_o(o_l[g]), .out_sel_o(o_s[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_v[d] = '0; in_l[d] = '0; in_d[d] = '0; o_rdy[d] = 1'b0;
        end
        tick();
        rst = 1'b0;
    endtask

    // Grant predicted from the rules: an owner keeps the grant, otherwise
    // the first valid in scan order (from ptr, or from 0 for fixed priority).
    function automatic int pick(input logic [N-1:0] v, input int own,
                                input int p, input bit prio);
        if (own >= 0) return own;
        for (int k = 0; k < N; k++) begin
            int j;
            j = prio ? k : (p + k) % N;
            if (v[j]) return j;
        end
        return prio ? 0 : p;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_v[d] = N'($urandom) | 4'b0001;
            in_l[d] = N'($urandom);
            in_d[d] = {$urandom, $urandom};
            o_rdy[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_v[d] !== 1'b0 || in_r[d] !== '0 || o_s[d] !== '0 ||
                o_d[d] !== '0 || o_l[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset d%0d: v=%b rdy=%b sel=%0d data=%h last=%b, required all 0",
                         d, o_v[d], in_r[d], o_s[d], o_d[d], o_l[d]);
            end
        end
        do_reset();
    endtask

    task automatic test_rr_rotation();
        do_reset();
        in_v[0] = 4'b1111; in_l[0] = 4'b1111; o_rdy[0] = 1'b1;
        in_d[0] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        for (int c = 0; c < 5; c++) begin
            logic [DW-1:0] ed;
            ed = DW'(32'h1111 * (c % 4));
            @(negedge clk);
            n_tests++;
            if (o_s[0] !== IW'(c % 4) || o_d[0] !== ed || o_v[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_rotation c%0d: sel=%0d data=%h, required sel=%0d data=%h",
                         c, o_s[0], o_d[0], c % 4, ed);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_v[0] = 4'b0101; in_l[0] = 4'b1111;
        in_d[0] = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int c = 0; c < 4; c++) begin
            logic [N-1:0] er;
            o_rdy[0] = (c == 3);
            er = (c == 3) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            n_tests++;
            if (o_s[0] !== 2'd0 || o_d[0] !== 16'hAAAA || o_v[0] !== 1'b1 || in_r[0] !== er) begin
                n_fail++;
                $display("FAIL stall c%0d: sel=%0d data=%h rdy=%b, required sel=0 data=aaaa rdy=%b",
                         c, o_s[0], o_d[0], in_r[0], er);
            end
            tick();
        end
        in_d[0][15:0] = 16'h5555;
        @(negedge clk);
        n_tests++;
        if (o_s[0] !== 2'd2 || o_d[0] !== 16'hCCCC) begin
            n_fail++;
            $display("FAIL stall_next: sel=%0d data=%h, required sel=2 data=cccc", o_s[0], o_d[0]);
        end
        tick();
    endtask

    task automatic test_burst_lock();
        int exp_s[5] = '{0, 1, 1, 1, 2};
        do_reset();
        in_v[1] = 4'b0111; in_l[1] = 4'b0101; o_rdy[1] = 1'b1;
        in_d[1] = {16'h0, 16'h2222, 16'h1100, 16'h0A0A};
        for (int c = 0; c < 5; c++) begin
            logic el;
            in_l[1][1] = (c == 3);
            in_d[1][DW +: DW] = DW'(16'h1100 + c);
            el = !(c == 1 || c == 2);
            @(negedge clk);
            n_tests++;
            if (o_s[1] !== IW'(exp_s[c]) || o_l[1] !== el) begin
                n_fail++;
                $display("FAIL burst_lock c%0d: sel=%0d last=%b, required sel=%0d last=%b",
                         c, o_s[1], o_l[1], exp_s[c], el);
            end
            tick();
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        in_v[2] = 4'b1110; o_rdy[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_l[2] = N'($urandom);
            in_d[2] = {$urandom, $urandom};
            @(negedge clk);
            n_tests++;
            if (o_s[2] !== 2'd1 || in_r[2] !== 4'b0010 || o_d[2] !== in_d[2][DW +: DW]) begin
                n_fail++;
                $display("FAIL fixed_prio c%0d: sel=%0d rdy=%b, required sel=1 rdy=0010",
                         c, o_s[2], in_r[2]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        in_v[0] = 4'b1000; in_l[0] = 4'b1111; o_rdy[0] = 1'b0;
        in_d[0] = {16'h3030, 16'h2020, 16'h1010, 16'h0000};
        @(negedge clk);
        n_tests++;
        if (o_s[0] !== 2'd3) begin
            n_fail++;
            $display("FAIL midlock_grant: sel=%0d, required 3", o_s[0]);
        end
        tick();
        in_v[0] = 4'b1111;
        @(negedge clk);
        n_tests++;
        if (o_s[0] !== 2'd3 || o_d[0] !== 16'h3030) begin
            n_fail++;
            $display("FAIL midlock_hold: sel=%0d data=%h, required sel=3 data=3030", o_s[0], o_d[0]);
        end
        tick();
        rst = 1'b1; o_rdy[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_v[0] !== 1'b0 || in_r[0] !== '0 || o_s[0] !== '0 || o_d[0] !== '0 || o_l[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midlock_rst: v=%b rdy=%b sel=%0d data=%h last=%b, required all 0",
                     o_v[0], in_r[0], o_s[0], o_d[0], o_l[0]);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_s[0] !== 2'd0 || in_r[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL midlock_after: sel=%0d rdy=%b, required sel=0 rdy=0001", o_s[0], in_r[0]);
        end
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        in_v[0] = 4'b0010; in_l[0] = 4'b1111; o_rdy[0] = 1'b1;
        in_d[0] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        @(negedge clk);
        n_tests++;
        if (o_s[0] !== 2'd1 || o_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_setup: sel=%0d v=%b, required sel=1 v=1", o_s[0], o_v[0]);
        end
        tick();
        in_v[0] = 4'b0000; o_rdy[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (o_v[0] !== 1'b0 || in_r[0] !== 4'b0000 || o_s[0] !== 2'd2) begin
                n_fail++;
                $display("FAIL idle c%0d: v=%b rdy=%b sel=%0d, required v=0 rdy=0000 sel=2",
                         c, o_v[0], in_r[0], o_s[0]);
            end
            tick();
        end
        in_v[0] = 4'b0101; o_rdy[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_s[0] !== 2'd2 || o_v[0] !== 1'b1 || o_d[0] !== 16'h3333) begin
            n_fail++;
            $display("FAIL idle_resume: sel=%0d v=%b data=%h, required sel=2 v=1 data=3333",
                     o_s[0], o_v[0], o_d[0]);
        end
        tick();
    endtask

    task automatic test_random();
        int owner[3], ptr[3], hs_idx[3];
        int rem[3][N];
        do_reset();
        for (int d = 0; d < 3; d++) begin
            owner[d] = -1; ptr[d] = 0; hs_idx[d] = -1;
            for (int i = 0; i < N; i++) rem[d][i] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            // Sources: keep valid/data until accepted, bursts keep valid between beats.
            for (int d = 0; d < 3; d++) begin
                o_rdy[d] = ($urandom_range(9) < 7);
                for (int i = 0; i < N; i++) begin
                    bit fresh;
                    fresh = 1'b0;
                    if (hs_idx[d] == i) begin
                        rem[d][i]--;
                        if (rem[d][i] == 0) in_v[d][i] = 1'b0;
                        else fresh = 1'b1;
                    end
                    if (!in_v[d][i] && $urandom_range(1) == 1) begin
                        rem[d][i] = $urandom_range(4, 1);
                        in_v[d][i] = 1'b1;
                        fresh = 1'b1;
                    end
                    if (fresh) begin
                        in_d[d][i*DW +: DW] = DW'($urandom);
                        in_l[d][i] = (rem[d][i] == 1);
                    end
                end
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                int s;
                logic ev, hs, dn;
                logic [N-1:0] er;
                s  = pick(in_v[d], owner[d], ptr[d], d == 2);
                ev = in_v[d][s];
                er = '0;
                if (o_rdy[d]) er[s] = 1'b1;
                n_tests++;
                if (o_v[d] !== ev || o_s[d] !== IW'(s) || o_d[d] !== in_d[d][s*DW +: DW] ||
                    o_l[d] !== in_l[d][s] || in_r[d] !== er) begin
                    n_fail++;
                    $display("FAIL random d%0d cyc%0d: v=%b sel=%0d data=%h last=%b rdy=%b, required v=%b sel=%0d data=%h last=%b rdy=%b",
                             d, cyc, o_v[d], o_s[d], o_d[d], o_l[d], in_r[d],
                             ev, s, in_d[d][s*DW +: DW], in_l[d][s], er);
                end
                hs = ev & o_rdy[d];
                dn = hs & ((d == 1) ? in_l[d][s] : 1'b1);
                hs_idx[d] = hs ? s : -1;
                if (dn) begin
                    owner[d] = -1;
                    ptr[d]   = (s + 1) % N;
                end else if (ev) begin
                    owner[d] = s;
                end
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_v[d] = '0; in_l[d] = '0; in_d[d] = '0; o_rdy[d] = 1'b0;
        end
        test_reset();
        test_rr_rotation();
        test_stall();
        test_burst_lock();
        test_fixed_prio();
        test_reset_mid_lock();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
